// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions used by the sprite DMA sequencer.
//   ADDR_OAM_DMA  : CPU write address that launches a sprite DMA ($4014)
//   ADDR_OAM_DATA : PPU OAM data port written by every DMA write cycle ($2004)
//   OAM_XFER_LEN  : bytes moved per transfer
//   dma_state_t   : sequencer states
package nes_bus_pkg;

  localparam logic [15:0] ADDR_OAM_DMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAM_DATA = 16'h2004;
  localparam int          OAM_XFER_LEN  = 256;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite (OAM) DMA sequencer.
// A CPU write to DMA_TRIG_ADDR latches the source page, halts the CPU, takes
// the bus and copies {page,00}..{page,FF} into OAM_DATA_ADDR as 256
// read/write pairs. Reads always start on an even CPU cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_ce              one-clk pulse per CPU cycle; the FSM only moves on it
//   cpu_addr/dout/wr    CPU bus, watched for the trigger write
//   bus_din             read data returned for a DMA read
//   cpu_halt            CPU clock-enable gate
//   bus_grant           bus mux select (1 = DMA owns the bus)
//   dma_addr/dout       DMA address and write data
//   dma_rd/dma_wr       DMA strobes
//   dma_busy            transfer in progress
module oam_dma_controller
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_TRIG_ADDR = ADDR_OAM_DMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAM_DATA,
  parameter int          XFER_LEN      = OAM_XFER_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic [7:0]  bus_din,
  output logic        cpu_halt,
  output logic        bus_grant,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic        dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       cpu_odd;
  logic       trig;

  assign trig = cpu_wr && (cpu_addr == DMA_TRIG_ADDR);

  // The byte latched during READ is the write data for the following WRITE.
  assign dma_dout = latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      latch     <= 8'h00;
      cpu_odd   <= 1'b0;
      cpu_halt  <= 1'b0;
      bus_grant <= 1'b0;
      dma_busy  <= 1'b0;
      dma_rd    <= 1'b0;
      dma_wr    <= 1'b0;
      dma_addr  <= 16'h0000;
    end else if (cpu_ce) begin
      cpu_odd <= ~cpu_odd;
      case (state)
        IDLE: begin
          // The trigger write itself completes on the CPU; the halt starts
          // with the next CPU cycle.
          if (trig) begin
            page      <= cpu_dout;
            state     <= HALT;
            cpu_halt  <= 1'b1;
            bus_grant <= 1'b1;
            dma_busy  <= 1'b1;
          end
        end
        HALT: begin
          // cpu_odd is this cycle's parity; the next cycle must be even
          // before the first read, otherwise spend one ALIGN cycle.
          if (!cpu_odd) begin
            state <= ALIGN;
          end else begin
            state    <= READ;
            dma_addr <= {page, idx};
            dma_rd   <= 1'b1;
          end
        end
        ALIGN: begin
          state    <= READ;
          dma_addr <= {page, idx};
          dma_rd   <= 1'b1;
        end
        READ: begin
          latch    <= bus_din;
          state    <= WRITE;
          dma_addr <= OAM_DATA_ADDR;
          dma_rd   <= 1'b0;
          dma_wr   <= 1'b1;
        end
        WRITE: begin
          // idx wraps to 0 on the last byte and never carries into page.
          idx    <= idx + 8'd1;
          dma_wr <= 1'b0;
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            cpu_halt  <= 1'b0;
            bus_grant <= 1'b0;
            dma_busy  <= 1'b0;
            dma_addr  <= 16'h0000;
          end else begin
            state    <= READ;
            dma_addr <= {page, idx + 8'd1};
            dma_rd   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: directed transfers checked cycle by cycle
// against a queue of expected bus cycles built from the transfer rules, plus
// hand-computed literal expectations.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  bus_din;
  logic        cpu_halt;
  logic        bus_grant;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rd;
  logic        dma_wr;
  logic        dma_busy;

  oam_dma_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_ce   (cpu_ce),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_wr   (cpu_wr),
    .bus_din  (bus_din),
    .cpu_halt (cpu_halt),
    .bus_grant(bus_grant),
    .dma_addr (dma_addr),
    .dma_dout (dma_dout),
    .dma_rd   (dma_rd),
    .dma_wr   (dma_wr),
    .dma_busy (dma_busy)
  );

  always #5 clk = ~clk;

  // Memory seen by the DMA read port.
  logic [7:0] mem [0:65535];
  assign bus_din = mem[dma_addr];

  int checks = 0;
  int passes = 0;

  // Model state, written only by the monitor.
  logic [28:0] exq[$];
  logic [7:0]  wlog[$];
  logic        mpar;
  int          halt_cnt = 0;
  int          dummy_cnt = 0;
  logic [15:0] last_rd;
  logic        first_rd_pending;
  logic        first_rd_par;

  // Stimulus state.
  logic        par_drv;
  logic        stall;
  int          x_halt, x_dummy, x_wb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One CPU cycle: optional idle clks, then a single cpu_ce clk.
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
    int gap;
    gap = stall ? 2 + int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      cpu_ce = 1'b0;
      cpu_wr = 1'b0;
      @(posedge clk); #1;
    end
    cpu_ce   = 1'b1;
    cpu_addr = a;
    cpu_dout = d;
    cpu_wr   = w;
    @(posedge clk); #1;
    cpu_ce  = 1'b0;
    cpu_wr  = 1'b0;
    par_drv = ~par_drv;
  endtask

  // Expected bus cycles for one transfer.
  task automatic push_xfer(input logic [7:0] p, input logic halt_par);
    logic [15:0] a;
    exq.push_back({5'b11100, 16'h0000, 8'h00});
    if (halt_par == 1'b0) exq.push_back({5'b11100, 16'h0000, 8'h00});
    for (int i = 0; i < 256; i++) begin
      a = {p, 8'(i)};
      exq.push_back({5'b11110, a, 8'h00});
      exq.push_back({5'b11101, 16'h2004, mem[a]});
    end
    first_rd_pending = 1'b1;
  endtask

  task automatic monitor();
    logic [28:0] act, full, e, snap;
    logic        was_idle, snap_ok, prev_ce;
    snap_ok = 1'b0;
    prev_ce = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exq.delete();
        mpar    = 1'b0;
        snap_ok = 1'b0;
        prev_ce = 1'b0;
        continue;
      end
      full = {cpu_halt, bus_grant, dma_busy, dma_rd, dma_wr, dma_addr, dma_dout};
      act  = {cpu_halt, bus_grant, dma_busy, dma_rd, dma_wr,
              (dma_rd || dma_wr) ? dma_addr : 16'h0000,
              dma_wr ? dma_dout : 8'h00};
      if (cpu_ce) begin
        was_idle = (exq.size() == 0);
        e = was_idle ? 29'h0 : exq.pop_front();
        chk("bus_cycle", 64'(act), 64'(e));
        if (cpu_halt) halt_cnt++;
        if (cpu_halt && !dma_rd && !dma_wr) dummy_cnt++;
        if (dma_rd) begin
          last_rd = dma_addr;
          if (first_rd_pending) begin
            first_rd_par     = mpar;
            first_rd_pending = 1'b0;
          end
        end
        if (dma_wr) wlog.push_back(dma_dout);
        if (was_idle && cpu_wr && cpu_addr == 16'h4014) push_xfer(cpu_dout, ~mpar);
        mpar = ~mpar;
      end else if (snap_ok && !prev_ce) begin
        chk("hold_while_ce_low", 64'(full), 64'(snap));
      end
      snap    = full;
      snap_ok = 1'b1;
      prev_ce = cpu_ce;
    end
  endtask

  // Trigger a transfer with HALT landing on an odd (or even) CPU cycle and
  // run it to completion.
  task automatic xfer(input logic [7:0] p, input logic odd_halt);
    int hb, db, n;
    if (par_drv != (odd_halt ? 1'b0 : 1'b1)) cyc(16'h0000, 8'h00, 1'b0);
    hb   = halt_cnt;
    db   = dummy_cnt;
    x_wb = wlog.size();
    cyc(16'h4014, p, 1'b1);
    cyc(16'h4014, 8'h77, 1'b1);
    n = 0;
    while (dma_busy && n < 1000) begin
      cyc(16'h0000, 8'h00, 1'b0);
      n++;
    end
    chk("xfer_done", 64'(dma_busy), 64'd0);
    x_halt  = halt_cnt - hb;
    x_dummy = dummy_cnt - db;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    int n;
    for (int i = 0; i < 65536; i++) begin
      a = 16'(i);
      mem[i] = a[7:0] ^ 8'h5A ^ ((a[15:8] == 8'h02) ? 8'h00 : a[15:8]);
    end
    rst_n    = 1'b0;
    cpu_ce   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_wr   = 1'b0;
    stall    = 1'b0;
    par_drv  = 1'b0;
    mpar     = 1'b0;
    last_rd  = 16'h0000;
    first_rd_pending = 1'b0;
    first_rd_par     = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({cpu_halt, bus_grant, dma_busy, dma_rd, dma_wr, dma_addr, dma_dout}), 64'd0);
    rst_n = 1'b1;

    // Basic transfer, HALT on an odd cycle.
    xfer(8'h02, 1'b1);
    chk("basic_halt_cycles", 64'(x_halt), 64'd513);
    chk("basic_dummy_cycles", 64'(x_dummy), 64'd1);
    chk("basic_first_rd_parity", 64'(first_rd_par), 64'd0);
    chk("basic_write_count", 64'(wlog.size() - x_wb), 64'd256);
    chk("basic_byte0", 64'(wlog[x_wb]), 64'h5A);
    chk("basic_byte1", 64'(wlog[x_wb + 1]), 64'h5B);
    chk("basic_byte2", 64'(wlog[x_wb + 2]), 64'h58);
    chk("basic_byte255", 64'(wlog[x_wb + 255]), 64'hA5);
    chk("basic_last_read", 64'(last_rd), 64'h02FF);

    // Alignment: HALT on an even cycle.
    xfer(8'h02, 1'b0);
    chk("align_halt_cycles", 64'(x_halt), 64'd514);
    chk("align_dummy_cycles", 64'(x_dummy), 64'd2);
    chk("align_first_rd_parity", 64'(first_rd_par), 64'd0);

    // Non-trigger addresses and a read of $4014.
    cyc(16'h4013, 8'h02, 1'b1);
    cyc(16'h4015, 8'h02, 1'b1);
    cyc(16'h2014, 8'h02, 1'b1);
    cyc(16'h4014, 8'h02, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0);
    chk("nontrig_grant", 64'(bus_grant), 64'd0);
    chk("nontrig_busy", 64'(dma_busy), 64'd0);

    // Page $FF wraps within the page.
    xfer(8'hFF, 1'b1);
    chk("wrap_halt_cycles", 64'(x_halt), 64'd513);
    chk("wrap_last_read", 64'(last_rd), 64'hFFFF);
    chk("wrap_byte0", 64'(wlog[x_wb]), 64'hA5);
    chk("wrap_byte255", 64'(wlog[x_wb + 255]), 64'h5A);
    cyc(16'h0000, 8'h00, 1'b0);
    chk("wrap_idle_after", 64'({dma_rd, dma_wr, bus_grant}), 64'd0);

    // Reset in the middle of a transfer, during a READ.
    if (par_drv != 1'b0) cyc(16'h0000, 8'h00, 1'b0);
    x_wb = wlog.size();
    cyc(16'h4014, 8'h03, 1'b1);
    n = 0;
    while ((wlog.size() - x_wb) < 100 && n < 1000) begin
      cyc(16'h0000, 8'h00, 1'b0);
      n++;
    end
    chk("midreset_in_read", 64'(dma_rd), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({cpu_halt, bus_grant, dma_busy, dma_rd, dma_wr, dma_addr, dma_dout}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    par_drv = 1'b0;
    xfer(8'h03, 1'b1);
    chk("restart_halt_cycles", 64'(x_halt), 64'd513);
    chk("restart_byte0", 64'(wlog[x_wb]), 64'h59);

    // Clock-enable stalls.
    stall = 1'b1;
    xfer(8'h02, 1'b0);
    chk("stall_align_halt_cycles", 64'(x_halt), 64'd514);
    chk("stall_byte2", 64'(wlog[x_wb + 2]), 64'h58);
    xfer(8'h05, 1'b1);
    chk("stall_halt_cycles", 64'(x_halt), 64'd513);
    chk("stall_first_rd_parity", 64'(first_rd_par), 64'd0);
    stall = 1'b0;
    cyc(16'h0000, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
